// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO controller: register offsets, bus FSM states
// and a byte-strobe expansion helper.
package gpio_pkg;

  localparam logic [7:0] OFF_OUT    = 8'h00;
  localparam logic [7:0] OFF_OE     = 8'h04;
  localparam logic [7:0] OFF_IN     = 8'h08;
  localparam logic [7:0] OFF_STATUS = 8'h0C;
  localparam logic [7:0] OFF_MASK   = 8'h10;
  localparam logic [7:0] OFF_EDGE   = 8'h14;

  typedef enum logic {
    ST_IDLE,
    ST_RESP
  } bus_state_t;

  function automatic logic [31:0] strb_mask(input logic [3:0] strb);
    logic [31:0] m;
    m = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      m[8*i +: 8] = {8{strb[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/gpio_sync.sv
// Two-flop synchronizer for asynchronous pad inputs.
module gpio_sync #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_s1;
  logic [WIDTH-1:0] r_s2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
    end
  end

  assign o_q = r_s2;

endmodule

// File: rtl/gpio_ctrl.sv
// Memory-mapped GPIO block with a single-cycle-response bus interface.
// Define GPIO_IRQ_EN to build in STATUS/MASK/EDGE, edge detection and irq.
module gpio_ctrl
  import gpio_pkg::*;
#(
  parameter int unsigned GPIO_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              iomem_valid,
  output logic              iomem_ready,
  input  logic [3:0]        iomem_wstrb,
  input  logic [7:0]        iomem_addr,
  input  logic [31:0]       iomem_wdata,
  output logic [31:0]       iomem_rdata,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic [GPIO_W-1:0] gpio_out,
  output logic [GPIO_W-1:0] gpio_oeb,
  output logic              irq
);

  bus_state_t r_state;
  bus_state_t w_state_nxt;
  logic       w_accept;
  logic       r_ready;
  logic [31:0] r_rdata;
  logic [31:0] w_rd_val;

  logic [GPIO_W-1:0] r_out;
  logic [GPIO_W-1:0] r_oe;
  logic [GPIO_W-1:0] w_in;

  logic [5:0]        w_word;
  logic              w_wr;
  logic [31:0]       w_bmask32;
  logic [GPIO_W-1:0] w_wmask;
  logic [GPIO_W-1:0] w_wdata;
  logic              w_unused;

  assign w_word    = iomem_addr[7:2];
  assign w_wr      = (r_state == ST_RESP) && (iomem_wstrb != 4'h0);
  assign w_bmask32 = strb_mask(iomem_wstrb);
  assign w_wmask   = w_bmask32[GPIO_W-1:0];
  assign w_wdata   = iomem_wdata[GPIO_W-1:0];
  assign w_unused  = ^{iomem_addr[1:0], iomem_wdata, w_bmask32};

  gpio_sync #(
    .WIDTH(GPIO_W)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .i_d   (gpio_in),
    .o_q   (w_in)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (iomem_valid) begin
          w_state_nxt = ST_RESP;
          w_accept    = 1'b1;
        end
      end
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Read data is captured at acceptance and shown only during the ready cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_ready <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ready <= w_accept;
      r_rdata <= (w_accept && (iomem_wstrb == 4'h0)) ? w_rd_val : '0;
    end
  end

  assign iomem_ready = r_ready;
  assign iomem_rdata = r_rdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out <= '0;
      r_oe  <= '0;
    end else if (w_wr) begin
      if (w_word == OFF_OUT[7:2]) r_out <= (r_out & ~w_wmask) | (w_wdata & w_wmask);
      if (w_word == OFF_OE[7:2])  r_oe  <= (r_oe  & ~w_wmask) | (w_wdata & w_wmask);
    end
  end

  assign gpio_out = r_out;
  assign gpio_oeb = ~r_oe;

`ifdef GPIO_IRQ_EN
  logic [GPIO_W-1:0] r_status;
  logic [GPIO_W-1:0] r_mask;
  logic [GPIO_W-1:0] r_edge;
  logic [GPIO_W-1:0] r_hist;
  logic [1:0]        r_arm;
  logic              r_irq;
  logic [GPIO_W-1:0] w_edge_hit;
  logic [GPIO_W-1:0] w_clr;

  // Detection waits until both the sync stage and history hold real pad data.
  assign w_edge_hit = (r_arm == 2'd3) ? ((w_in ^ r_hist) & ~(w_in ^ r_edge)) : '0;
  assign w_clr      = (w_wr && (w_word == OFF_STATUS[7:2])) ? (w_wdata & w_wmask) : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_status <= '0;
      r_mask   <= '0;
      r_edge   <= '0;
      r_hist   <= '0;
      r_arm    <= '0;
      r_irq    <= 1'b0;
    end else begin
      r_hist   <= w_in;
      if (r_arm != 2'd3) r_arm <= r_arm + 2'd1;
      r_status <= (r_status & ~w_clr) | w_edge_hit;
      r_irq    <= |(r_status & r_mask);
      if (w_wr && (w_word == OFF_MASK[7:2])) r_mask <= (r_mask & ~w_wmask) | (w_wdata & w_wmask);
      if (w_wr && (w_word == OFF_EDGE[7:2])) r_edge <= (r_edge & ~w_wmask) | (w_wdata & w_wmask);
    end
  end

  assign irq = r_irq;
`else
  assign irq = 1'b0;
`endif

  always_comb begin
    w_rd_val = '0;
    case (w_word)
      OFF_OUT[7:2]:    w_rd_val = 32'(r_out);
      OFF_OE[7:2]:     w_rd_val = 32'(r_oe);
      OFF_IN[7:2]:     w_rd_val = 32'(w_in);
`ifdef GPIO_IRQ_EN
      OFF_STATUS[7:2]: w_rd_val = 32'(r_status);
      OFF_MASK[7:2]:   w_rd_val = 32'(r_mask);
      OFF_EDGE[7:2]:   w_rd_val = 32'(r_edge);
`endif
      default:         w_rd_val = '0;
    endcase
  end

endmodule

// File: tb/tb_gpio_ctrl.sv
// Scoreboard bench for gpio_ctrl: bus responses are checked by a monitor
// against expectations queued when each access is issued.
module tb_gpio_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        iomem_valid = 1'b0;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb = '0;
  logic [7:0]  iomem_addr = '0;
  logic [31:0] iomem_wdata = '0;
  logic [31:0] iomem_rdata;
  logic [15:0] gpio_in = '0;
  logic [15:0] gpio_out;
  logic [15:0] gpio_oeb;
  logic        irq;

  gpio_ctrl #(.GPIO_W(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .iomem_valid (iomem_valid),
    .iomem_ready (iomem_ready),
    .iomem_wstrb (iomem_wstrb),
    .iomem_addr  (iomem_addr),
    .iomem_wdata (iomem_wdata),
    .iomem_rdata (iomem_rdata),
    .gpio_in     (gpio_in),
    .gpio_out    (gpio_out),
    .gpio_oeb    (gpio_oeb),
    .irq         (irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_ready  = 0;

  typedef struct {
    logic [31:0] data;
    bit          chk;
    string       name;
  } exp_t;
  exp_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %h required %h", name, act, exp);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (iomem_ready === 1'b1) begin
      n_ready++;
      if (exp_q.size() == 0) begin
        check("unexpected_ready", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        if (e.chk) check(e.name, iomem_rdata, e.data);
      end
    end
  end

  task automatic bus(input logic [7:0] a, input logic [3:0] s, input logic [31:0] d,
                     input bit chk, input logic [31:0] exp, input string name);
    exp_t e;
    int unsigned lat;
    @(negedge clk);
    iomem_addr  = a;
    iomem_wstrb = s;
    iomem_wdata = d;
    iomem_valid = 1'b1;
    e.data = exp;
    e.chk  = chk;
    e.name = name;
    exp_q.push_back(e);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (iomem_ready !== 1'b1 && lat < 8);
    check({name, "_latency"}, lat, 32'd1);
    @(negedge clk);
    iomem_valid = 1'b0;
    @(posedge clk);
    #1;
    check({name, "_ready_1cyc"}, {31'd0, iomem_ready}, 32'd0);
    check({name, "_rdata_idle"}, iomem_rdata, 32'd0);
    iomem_wstrb = '0;
    iomem_addr  = '0;
    iomem_wdata = '0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [3:0] s, input logic [31:0] d);
    bus(a, s, d, 1'b0, 32'd0, "wr");
  endtask

  task automatic rd(input logic [7:0] a, input logic [31:0] exp, input string name);
    bus(a, 4'h0, 32'd0, 1'b1, exp, name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int nr;
    repeat (3) @(posedge clk);
    #1;
    check("rst_gpio_out", {16'd0, gpio_out}, 32'h0);
    check("rst_gpio_oeb", {16'd0, gpio_oeb}, 32'hFFFF);
    check("rst_ready", {31'd0, iomem_ready}, 32'd0);
    check("rst_rdata", iomem_rdata, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(posedge clk);

    // Output drive
    wr(8'h00, 4'hF, 32'h0000_A000);
    wr(8'h04, 4'hF, 32'h0000_FF00);
    check("drive_out_hi", {24'd0, gpio_out[15:8]}, 32'hA0);
    check("drive_out", {16'd0, gpio_out}, 32'hA000);
    check("drive_oeb", {16'd0, gpio_oeb}, 32'h00FF);
    rd(8'h00, 32'h0000_A000, "rd_out");
    rd(8'h04, 32'h0000_FF00, "rd_oe");

    // Byte strobes and width clipping
    wr(8'h00, 4'h1, 32'h1234_5555);
    rd(8'h00, 32'h0000_A055, "strb_low_byte");
    wr(8'h04, 4'hC, 32'hFFFF_FFFF);
    rd(8'h04, 32'h0000_FF00, "strb_above_width");
    rd(8'h01, 32'h0000_A055, "addr_low_bits_ignored");
    wr(8'h18, 4'hF, 32'hFFFF_FFFF);
    rd(8'h18, 32'h0, "unmapped");
    rd(8'h00, 32'h0000_A055, "unmapped_no_alias");

    // Input synchronizer: IN shows the pad, not OUT
    @(negedge clk);
    gpio_in = 16'h00F0;
    rd(8'h08, 32'h0000_0000, "in_not_early");
    rd(8'h08, 32'h0000_00F0, "in_synced");

`ifdef GPIO_IRQ_EN
    wr(8'h14, 4'hF, 32'h0000_0001);
    wr(8'h10, 4'hF, 32'h0000_0001);
    @(negedge clk);
    gpio_in[0] = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("rise_irq", {31'd0, irq}, 32'd1);
    rd(8'h0C, 32'h0000_0001, "rise_status");
    wr(8'h0C, 4'hF, 32'h0000_0001);
    check("w1c_irq_lag", {31'd0, irq}, 32'd1);
    @(posedge clk);
    #1;
    check("w1c_irq_clear", {31'd0, irq}, 32'd0);
    rd(8'h0C, 32'h0000_0000, "w1c_status");

    @(negedge clk);
    gpio_in[1] = 1'b1;
    repeat (6) @(posedge clk);
    rd(8'h0C, 32'h0000_0000, "rise_ignored_falling_mode");
    @(negedge clk);
    gpio_in[1] = 1'b0;
    wr(8'h0C, 4'hF, 32'h0000_0002);
    rd(8'h0C, 32'h0000_0002, "set_beats_clear");
    check("masked_no_irq", {31'd0, irq}, 32'd0);
    wr(8'h10, 4'hF, 32'h0000_0003);
    check("unmask_irq_lag", {31'd0, irq}, 32'd0);
    @(posedge clk);
    #1;
    check("unmask_irq", {31'd0, irq}, 32'd1);
`else
    wr(8'h0C, 4'hF, 32'hFFFF_FFFF);
    wr(8'h10, 4'hF, 32'hFFFF_FFFF);
    wr(8'h14, 4'hF, 32'hFFFF_FFFF);
    rd(8'h0C, 32'h0, "noirq_status");
    rd(8'h10, 32'h0, "noirq_mask");
    rd(8'h14, 32'h0, "noirq_edge");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      gpio_in = ~gpio_in;
      repeat (4) @(posedge clk);
      #1;
      check("noirq_irq", {31'd0, irq}, 32'd0);
    end
    rd(8'h08, 32'h0000_00F0, "noirq_in_after_toggle");
`endif

    // Reset while the write to OUT is in its response cycle
    @(negedge clk);
    iomem_addr  = 8'h00;
    iomem_wstrb = 4'hF;
    iomem_wdata = 32'h0000_1234;
    iomem_valid = 1'b1;
    @(posedge clk);
    #1;
    check("mid_in_resp", {31'd0, iomem_ready}, 32'd1);
    reset = 1'b1;
    #1;
    nr = n_ready;
    iomem_valid = 1'b0;
    check("mid_ready_drop", {31'd0, iomem_ready}, 32'd0);
    repeat (2) @(negedge clk);
    iomem_wstrb = '0;
    iomem_wdata = '0;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("mid_out", {16'd0, gpio_out}, 32'h0);
    check("mid_no_ready", n_ready, nr);
    check("mid_irq", {31'd0, irq}, 32'd0);
    rd(8'h00, 32'h0, "mid_rd_out");

    check("queue_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/gpio_ctrl.md
GPIO_CTRL -- requirements
Module: gpio_ctrl

Interface
REQ-001 SHALL have parameter GPIO_W, default 16, number of GPIO pins (legal range 1..32).
REQ-002 SHALL have port clk, input, 1: single clock, rising-edge.
REQ-003 SHALL have port reset, input, 1: reset, asynchronous and active-high.
REQ-004 SHALL have port iomem_valid, input, 1: bus request.
REQ-005 SHALL have port iomem_ready, output, 1: bus completion pulse.
REQ-006 SHALL have port iomem_wstrb, input, 4: byte write strobes; 0 means read.
REQ-007 SHALL have port iomem_addr, input, 8: byte address; bits [1:0] are ignored.
REQ-008 SHALL have port iomem_wdata, input, 32: write data.
REQ-009 SHALL have port iomem_rdata, output, 32: read data.
REQ-010 SHALL have port gpio_in, input, GPIO_W: raw pad inputs (asynchronous).
REQ-011 SHALL have port gpio_out, output, GPIO_W: pad output values.
REQ-012 SHALL have port gpio_oeb, output, GPIO_W: pad output enables, active-low.
REQ-013 SHALL have port irq, output, 1: level interrupt.

Function
REQ-014 SHALL use register map: 0x00 OUT rw; 0x04 OE rw (1=drive); 0x08 IN ro; 0x0C STATUS w1c; 0x10 MASK rw; 0x14 EDGE rw (1=rising, 0=falling); any other offset reads 0 and ignores writes.
REQ-015 SHALL run a bus FSM with states IDLE and RESP.
  - IDLE->RESP on iomem_valid.
  - RESP asserts iomem_ready for exactly 1 cycle, then returns to IDLE.
  - Latency is 1 cycle, no back-to-back acceptance.
REQ-016 SHALL sample write data and apply the register update in the RESP cycle.
  - wstrb[n] enables bits [8n+7:8n].
  - Bits >= GPIO_W read 0.
REQ-017 SHALL hold iomem_rdata valid only while iomem_ready=1 and drive 0 otherwise.
REQ-018 SHALL drive gpio_out=OUT and gpio_oeb=~OE combinationally from registers.
REQ-019 SHALL pass gpio_in through a 2-flop synchronizer; IN reads the second stage.
  - Pad change is visible in IN 2 cycles after the first clk edge that samples it.
REQ-020 SHALL compare the second synchronizer stage with a third history flop for edge detection.
  - An edge matching EDGE[i] sets STATUS[i].
REQ-021 SHALL let the set win over the clear when an edge and a STATUS w1c hit the same bit in the same cycle.
REQ-022 SHALL drive irq as a registered OR of (STATUS & MASK), updated 1 cycle after STATUS changes.
REQ-023 SHALL still record STATUS for masked bits; unmasking a pending bit raises irq on the next cycle.
REQ-024 SHALL NOT have undriven pins (OE=0) read back OUT; IN always reflects the pad.

Reset
REQ-025 SHALL asynchronously clear all of the following on reset: OUT, OE, STATUS, MASK, EDGE, synchronizer and history flops, FSM (to IDLE), iomem_ready, iomem_rdata, irq.
  - With OE=0 after reset, gpio_oeb is all ones.
REQ-026 SHALL abort an in-flight access when reset asserts mid-transaction; no ready is issued and no register is written.
REQ-027 SHALL NOT flag spurious edges on the first cycles after reset release: history is loaded from the sync stage for 2 cycles before detection is enabled.

Configuration
REQ-028 SHALL compile in STATUS/MASK/EDGE, edge detection and irq when GPIO_IRQ_EN is defined.
REQ-029 SHALL, when GPIO_IRQ_EN is undefined:
  - make offsets 0x0C-0x14 read 0 and ignore writes;
  - tie irq to 0;
  - omit the history flop.

Structure
REQ-030 SHALL place the register offset localparams and the FSM state enum in shared package gpio_pkg.
REQ-031 SHALL implement the synchronizer as sub-module gpio_sync (parameter WIDTH, 2-flop, async-high reset).

Verification
REQ-032 SHALL cover output drive: write OUT=0xA000, OE=0xFF00 -> gpio_out[15:8]=0xA0, gpio_oeb=0x00FF, iomem_ready 1 cycle after valid.
REQ-033 SHALL cover input sync: gpio_in[7:0] 0x00->0xF0 -> IN reads 0x00F0 no earlier than 2 cycles later and never shows 0xF0 on the first edge.
REQ-034 SHALL cover the rising interrupt: EDGE=0x0001, MASK=0x0001, gpio_in[0] 0->1 -> STATUS=0x0001 and irq=1.
  - w1c 0x0001 -> irq=0 one cycle after STATUS clears.
REQ-035 SHALL cover simultaneous set/clear: w1c STATUS bit 1 in the same cycle a falling edge on pin 1 (EDGE[1]=0) is detected -> STATUS[1] stays 1.
REQ-036 SHALL cover reset mid-access: assert reset while FSM is in RESP with a write OUT=0x1234 -> OUT=0, no iomem_ready pulse, irq=0.
REQ-037 SHALL cover the build without GPIO_IRQ_EN: read 0x0C/0x10/0x14 -> 0; toggle all gpio_in -> irq stays 0.
